// File: rtl/branch_cond_if.sv
// Branch request / PC-load handshake bundle between the control sequencer,
// the branch condition evaluator and the program counter.
//   master : control sequencer + PC side (drives requests and pc_ack)
//   slave  : branch_cond (drives status, result and the PC-load request)
interface branch_cond_if #(
    parameter int ADDR_W = 16
);
    logic              br_req;
    logic [3:0]        br_cond;
    logic [ADDR_W-1:0] br_target;
    logic              br_busy;
    logic              br_taken;
    logic              br_done;
    logic              cond_err;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_target;
    logic              pc_ack;

    modport master (
        output br_req, br_cond, br_target, pc_ack,
        input  br_busy, br_taken, br_done, cond_err, pc_load, pc_target
    );

    modport slave (
        input  br_req, br_cond, br_target, pc_ack,
        output br_busy, br_taken, br_done, cond_err, pc_load, pc_target
    );
endinterface

// File: rtl/branch_cond.sv
// Conditional-branch evaluator on the Z/C/S flag bus.
// Captures a branch request, waits for in-flight ALU ops and flag settling,
// samples the flags once, and requests a PC load when the branch is taken.
// Optional build macro BR_STATS_EN adds saturating taken/evaluation counters;
// without it taken_cnt and eval_cnt read 0.
module branch_cond #(
    parameter int ADDR_W        = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          flags_in,
    input  logic                flag_wait,
    branch_cond_if.slave        bus,
    output logic [15:0]         taken_cnt,
    output logic [15:0]         eval_cnt
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        EVAL,
        LOAD,
        DONE
    } state_t;

    state_t            state_q;
    logic [3:0]        settle_cnt_q;
    logic [3:0]        cond_q;
    logic [ADDR_W-1:0] target_q;
    logic              busy_q;
    logic              taken_q;
    logic              done_q;
    logic              cond_err_q;
    logic              pc_load_q;
    logic [ADDR_W-1:0] pc_target_q;
    logic              taken_d;

    // Flag bus layout: [0]=Z, [1]=C, [2]=S. Reserved codes evaluate not taken.
    function automatic logic cond_taken(input logic [3:0] c, input logic [2:0] f);
        logic z, cy, s;
        z  = f[0];
        cy = f[1];
        s  = f[2];
        case (c)
            4'd0:    cond_taken = 1'b1;
            4'd1:    cond_taken = 1'b0;
            4'd2:    cond_taken = z;
            4'd3:    cond_taken = !z;
            4'd4:    cond_taken = cy;
            4'd5:    cond_taken = !cy;
            4'd6:    cond_taken = s;
            4'd7:    cond_taken = !s;
            4'd8:    cond_taken = z | s;
            4'd9:    cond_taken = !z & !s;
            default: cond_taken = 1'b0;
        endcase
    endfunction

    function automatic logic cond_reserved(input logic [3:0] c);
        cond_reserved = (c > 4'd9);
    endfunction

    // Branch decision from the live flag bus; only consumed in EVAL.
    always_comb begin
        taken_d = cond_taken(cond_q, flags_in);
    end

    // Branch sequencer with registered handshake outputs.
    // SETTLE is left once the counter has reached 1 (or was loaded with 0), so
    // SETTLE spans max(SETTLE_CYCLES,1) quiet cycles and a request reaches
    // br_done SETTLE_CYCLES+2 cycles later (not taken) or +3 (taken, immediate ack).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            settle_cnt_q <= 4'd0;
            cond_q       <= 4'd0;
            target_q     <= '0;
            busy_q       <= 1'b0;
            taken_q      <= 1'b0;
            done_q       <= 1'b0;
            cond_err_q   <= 1'b0;
            pc_load_q    <= 1'b0;
            pc_target_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.br_req) begin
                        state_q      <= SETTLE;
                        cond_q       <= bus.br_cond;
                        target_q     <= bus.br_target;
                        settle_cnt_q <= SETTLE_INIT;
                        busy_q       <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (flag_wait) begin
                        settle_cnt_q <= SETTLE_INIT;
                    end else if (settle_cnt_q <= 4'd1) begin
                        settle_cnt_q <= 4'd0;
                        state_q      <= EVAL;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - 4'd1;
                    end
                end
                EVAL: begin
                    taken_q <= taken_d;
                    if (taken_d) begin
                        state_q     <= LOAD;
                        pc_load_q   <= 1'b1;
                        pc_target_q <= target_q;
                    end else begin
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        cond_err_q <= cond_reserved(cond_q);
                    end
                end
                LOAD: begin
                    if (bus.pc_ack) begin
                        state_q   <= DONE;
                        pc_load_q <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    done_q     <= 1'b0;
                    cond_err_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.br_busy   = busy_q;
    assign bus.br_taken  = taken_q;
    assign bus.br_done   = done_q;
    assign bus.cond_err  = cond_err_q;
    assign bus.pc_load   = pc_load_q;
    assign bus.pc_target = pc_target_q;

`ifdef BR_STATS_EN
    logic [15:0] taken_cnt_q, taken_cnt_d;
    logic [15:0] eval_cnt_q, eval_cnt_d;

    // Saturating statistics, bumped once per completed branch (DONE cycle).
    always_comb begin
        taken_cnt_d = taken_cnt_q;
        eval_cnt_d  = eval_cnt_q;
        if (state_q == DONE) begin
            if (eval_cnt_q != 16'hFFFF) begin
                eval_cnt_d = eval_cnt_q + 16'd1;
            end
            if (taken_q && (taken_cnt_q != 16'hFFFF)) begin
                taken_cnt_d = taken_cnt_q + 16'd1;
            end
        end
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_q <= 16'd0;
            eval_cnt_q  <= 16'd0;
        end else begin
            taken_cnt_q <= taken_cnt_d;
            eval_cnt_q  <= eval_cnt_d;
        end
    end

    assign taken_cnt = taken_cnt_q;
    assign eval_cnt  = eval_cnt_q;
`else
    assign taken_cnt = 16'd0;
    assign eval_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_branch_cond.sv
// Directed bench for branch_cond (SETTLE_CYCLES=2, ADDR_W=16).
module tb_branch_cond;

    logic        clk;
    logic        rst_n;
    logic [2:0]  flags_in;
    logic        flag_wait;
    logic [15:0] taken_cnt;
    logic [15:0] eval_cnt;

    int tests;
    int fails;

    // Results of the last run_branch call
    int   r_done_n;
    int   r_load_cycles;
    int   r_extra_done;
    logic r_saw_load;
    logic r_tgt_ok;
    logic r_err;
    logic r_taken;

    branch_cond_if #(.ADDR_W(16)) bus ();

    branch_cond #(
        .ADDR_W(16),
        .SETTLE_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flags_in(flags_in),
        .flag_wait(flag_wait),
        .bus(bus.slave),
        .taken_cnt(taken_cnt),
        .eval_cnt(eval_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Issue one branch and watch it for up to 40 cycles. done_n counts clock
    // edges after the request edge until br_done is seen. ack_delay<0 ties
    // pc_ack high; otherwise pc_ack rises after pc_load was seen ack_delay+1 times.
    task automatic run_branch(input logic [3:0] cond, input logic [15:0] tgt,
                              input logic [2:0] fpre, input logic [2:0] fpost,
                              input int flip_n, input int wait_len,
                              input int ack_delay, input bit inject);
        r_done_n      = -1;
        r_load_cycles = 0;
        r_extra_done  = 0;
        r_saw_load    = 1'b0;
        r_tgt_ok      = 1'b1;
        r_err         = 1'b0;
        r_taken       = 1'b0;
        bus.pc_ack    = (ack_delay < 0);
        flags_in      = (flip_n > 0) ? fpre : fpost;
        flag_wait     = (wait_len > 0);
        bus.br_cond   = cond;
        bus.br_target = tgt;
        bus.br_req    = 1'b1;
        @(posedge clk); #1;
        bus.br_req    = 1'b0;
        bus.br_cond   = 4'hB;
        bus.br_target = ~tgt;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (bus.pc_load) begin
                r_saw_load = 1'b1;
                r_load_cycles++;
                if (bus.pc_target !== tgt) r_tgt_ok = 1'b0;
            end
            if (bus.br_done) begin
                if (r_done_n < 0) begin
                    r_done_n = n;
                    r_err    = bus.cond_err;
                    r_taken  = bus.br_taken;
                end else begin
                    r_extra_done++;
                end
            end
            flag_wait  = (n < wait_len);
            flags_in   = (n < flip_n) ? fpre : fpost;
            bus.pc_ack = (ack_delay < 0) || (r_load_cycles > ack_delay);
            bus.br_req = inject && bus.pc_load && (r_load_cycles == 1);
            if (r_done_n > 0 && n >= r_done_n + 4) break;
        end
        bus.br_req = 1'b0;
        bus.pc_ack = 1'b0;
        flag_wait  = 1'b0;
    endtask

    logic [3:0] tab_cond [10];
    logic [2:0] tab_flag [10];
    logic       tab_take [10];
    int         got;

    initial begin
        tests         = 0;
        fails         = 0;
        rst_n         = 1'b0;
        flags_in      = 3'b000;
        flag_wait     = 1'b0;
        bus.br_req    = 1'b0;
        bus.br_cond   = 4'd0;
        bus.br_target = 16'h0000;
        bus.pc_ack    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   32'(bus.br_busy),   32'd0);
        check("rst_load",   32'(bus.pc_load),   32'd0);
        check("rst_target", 32'(bus.pc_target), 32'd0);
        check("rst_done",   32'(bus.br_done),   32'd0);
        check("rst_taken",  32'(bus.br_taken),  32'd0);
        check("rst_evalc",  32'(eval_cnt),      32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of LOAD
        bus.pc_ack    = 1'b0;
        bus.br_cond   = 4'd0;
        bus.br_target = 16'h5555;
        bus.br_req    = 1'b1;
        @(posedge clk); #1;
        bus.br_req = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(posedge clk); #1;
            if (bus.pc_load) got = 1;
        end
        check("mid_load_reached", 32'(got), 32'd1);
        check("mid_load_taken", 32'(bus.br_taken), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_load",  32'(bus.pc_load),  32'd0);
        check("arst_busy",  32'(bus.br_busy),  32'd0);
        check("arst_taken", 32'(bus.br_taken), 32'd0);
        check("arst_takc",  32'(taken_cnt),    32'd0);
        check("arst_evalc", 32'(eval_cnt),     32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", 32'(bus.br_busy), 32'd0);
        check("post_rst_load", 32'(bus.pc_load), 32'd0);
        check("post_rst_done", 32'(bus.br_done), 32'd0);

        // Z taken: done 5 cycles after the request cycle, target loaded
        run_branch(4'd2, 16'h1234, 3'b001, 3'b001, 0, 0, -1, 1'b0);
        check("z_taken_done_n", 32'(r_done_n),   32'd4);
        check("z_taken_load",   32'(r_saw_load), 32'd1);
        check("z_taken_tgt",    32'(r_tgt_ok),   32'd1);
        check("z_taken_bit",    32'(r_taken),    32'd1);
        check("z_taken_err",    32'(r_err),      32'd0);
        check("z_taken_idle",   32'(bus.br_busy), 32'd0);

        // Z not taken: done 4 cycles after the request cycle, no PC load
        run_branch(4'd2, 16'h1234, 3'b000, 3'b000, 0, 0, -1, 1'b0);
        check("z_nt_done_n", 32'(r_done_n),   32'd3);
        check("z_nt_load",   32'(r_saw_load), 32'd0);
        check("z_nt_bit",    32'(r_taken),    32'd0);

        // flag_wait held 6 cycles, C rises during the wait
        run_branch(4'd4, 16'h0F0F, 3'b000, 3'b010, 3, 6, -1, 1'b0);
        check("wait_done_n", 32'(r_done_n), 32'd10);
        check("wait_taken",  32'(r_taken),  32'd1);
        check("wait_tgt",    32'(r_tgt_ok), 32'd1);

        // Delayed ack with a second request dropped during LOAD
        run_branch(4'd0, 16'hABCD, 3'b000, 3'b000, 0, 0, 3, 1'b1);
        check("ack_load_cycles", 32'(r_load_cycles), 32'd4);
        check("ack_tgt",         32'(r_tgt_ok),      32'd1);
        check("ack_done_n",      32'(r_done_n),      32'd7);
        check("ack_single_done", 32'(r_extra_done),  32'd0);
        check("ack_idle_busy",   32'(bus.br_busy),   32'd0);

        // Reserved code
        run_branch(4'hC, 16'h7777, 3'b111, 3'b111, 0, 0, -1, 1'b0);
        check("rsv_done_n", 32'(r_done_n),   32'd3);
        check("rsv_err",    32'(r_err),      32'd1);
        check("rsv_load",   32'(r_saw_load), 32'd0);
        check("rsv_taken",  32'(r_taken),    32'd0);

        // Condition code table
        tab_cond = '{4'd0, 4'd1, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd9, 4'd15};
        tab_flag = '{3'b000, 3'b111, 3'b000, 3'b010, 3'b100, 3'b100, 3'b100, 3'b000, 3'b001, 3'b000};
        tab_take = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 10; k++) begin
            run_branch(tab_cond[k], 16'h2000 + 16'(k), tab_flag[k], tab_flag[k], 0, 0, -1, 1'b0);
            check($sformatf("cond%0d_taken", k), 32'(r_taken),    32'(tab_take[k]));
            check($sformatf("cond%0d_load", k),  32'(r_saw_load), 32'(tab_take[k]));
            check($sformatf("cond%0d_done_n", k), 32'(r_done_n),  tab_take[k] ? 32'd4 : 32'd3);
            check($sformatf("cond%0d_err", k),   32'(r_err),      (k == 9) ? 32'd1 : 32'd0);
        end

        // Statistics: 3 taken + 2 not taken from a fresh reset
        rst_n = 1'b0;
        #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            run_branch((k < 3) ? 4'd0 : 4'd1, 16'h3000, 3'b000, 3'b000, 0, 0, -1, 1'b0);
        end
`ifdef BR_STATS_EN
        check("stats_taken", 32'(taken_cnt), 32'd3);
        check("stats_eval",  32'(eval_cnt),  32'd5);
        force dut.eval_cnt_q  = 16'hFFFE;
        force dut.taken_cnt_q = 16'hFFFE;
        @(posedge clk); #1;
        release dut.eval_cnt_q;
        release dut.taken_cnt_q;
        for (int k = 0; k < 2; k++) begin
            run_branch(4'd0, 16'h4000, 3'b000, 3'b000, 0, 0, -1, 1'b0);
        end
        check("sat_taken", 32'(taken_cnt), 32'hFFFF);
        check("sat_eval",  32'(eval_cnt),  32'hFFFF);
`else
        check("stats_off_taken", 32'(taken_cnt), 32'd0);
        check("stats_off_eval",  32'(eval_cnt),  32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
